count_group_expander: RTL and testbench

Inverse of the counter-to-group bucketing stage. It accepts a group code over a valid/ready input and expands it back into the consecutive counter values that belong to that group, one value per beat, over a valid/ready output. With defaults, group 1 expands to 1,2,3, group 2 to 4,5,6, and group 3 to 7,8,9. It sits downstream of the group encoder, so tests can regenerate and cross-check the original count stream.

---
 rtl/count_group_expander.sv | 147 ++++++++++++++
 tb/tb_count_group_expander.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/count_group_expander.sv
// count_group_expander
// Expands a group code back into the consecutive counter values of that group,
// one value per output beat. Group g covers values (g-1)*GROUP_SIZE+1 up to
// g*GROUP_SIZE. Illegal codes are dropped and flagged with a one-cycle err pulse.
module count_group_expander #(
   parameter int W          = 4,
   parameter int GROUP_SIZE = 3,
   parameter int MAX_GROUP  = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_group,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_value,
   output logic         out_last,
   output logic         err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic [W-1:0]   LAST_K   = W'(GROUP_SIZE - 1);
   localparam logic [W-1:0]   MAX_CODE = W'(MAX_GROUP);
   localparam logic [2*W-1:0] GS_WIDE  = (2*W)'(GROUP_SIZE);
   localparam logic [2*W-1:0] ONE_WIDE = (2*W)'(1);
   localparam logic [W-1:0]   ONE      = W'(1);

   // The largest legal group must still fit in the output value width.
   if (MAX_GROUP * GROUP_SIZE > (2**W) - 1) begin : g_bad_params
      $error("count_group_expander: MAX_GROUP*GROUP_SIZE exceeds 2^W-1");
   end

   state_t         state_q, state_d;
   logic [W-1:0]   base_q, base_d;
   logic [W-1:0]   k_q, k_d;
   logic [W-1:0]   out_value_q, out_value_d;
   logic           out_last_q, out_last_d;
   logic           err_q, err_d;

   logic [2*W-1:0] grp_wide_s;
   logic [W-1:0]   base_s;
   logic           legal_s;
   logic           in_ready_s;
   logic           accept_s;
   logic           beat_s;

   // Decode the incoming code: legality and the first value of its group.
   always_comb begin
      grp_wide_s = {{W{1'b0}}, in_group};
      // Wide arithmetic so (g-1)*GROUP_SIZE cannot wrap before truncation.
      base_s     = W'((grp_wide_s - ONE_WIDE) * GS_WIDE + ONE_WIDE);
      legal_s    = (in_group != {W{1'b0}}) && (in_group <= MAX_CODE);
   end

   // Input acceptance: open in IDLE, or on the final beat being taken; never from in_valid.
   always_comb begin
      in_ready_s = 1'b0;
      if (reset) begin
         in_ready_s = 1'b0;
      end else if (state_q == ST_EMIT) begin
         in_ready_s = out_ready && out_last_q;
      end else begin
         in_ready_s = 1'b1;
      end
      accept_s = in_valid && in_ready_s;
      beat_s   = (state_q == ST_EMIT) && out_ready;
   end

   // Next-state and next-output computation for the expander FSM.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      k_d         = k_q;
      out_value_d = out_value_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && legal_s) begin
               state_d     = ST_EMIT;
               base_d      = base_s;
               k_d         = {W{1'b0}};
               out_value_d = base_s;
               out_last_d  = (LAST_K == {W{1'b0}});
            end else if (accept_s) begin
               err_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (beat_s && !out_last_q) begin
               k_d         = k_q + ONE;
               out_value_d = base_q + k_q + ONE;
               out_last_d  = ((k_q + ONE) == LAST_K);
            end else if (beat_s && accept_s && legal_s) begin
               // Chain straight into the next group with no idle cycle.
               base_d      = base_s;
               k_d         = {W{1'b0}};
               out_value_d = base_s;
               out_last_d  = (LAST_K == {W{1'b0}});
            end else if (beat_s) begin
               state_d    = ST_IDLE;
               out_last_d = 1'b0;
               err_d      = accept_s;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            out_last_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         base_q      <= {W{1'b0}};
         k_q         <= {W{1'b0}};
         out_value_q <= {W{1'b0}};
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         k_q         <= k_d;
         out_value_q <= out_value_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = (state_q == ST_EMIT);
   assign out_value = out_value_q;
   assign out_last  = out_last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_count_group_expander.sv
// Directed self-checking bench for count_group_expander with default parameters.
module tb_count_group_expander;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_group;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_value;
   logic       out_last;
   logic       err;

   int n_checks;
   int n_fail;

   count_group_expander #(.W(4), .GROUP_SIZE(3), .MAX_GROUP(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_group  (in_group),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_last  (out_last),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check a presented beat: valid, value, last flag and in_ready.
   task automatic beat(input string tag, input int val, input int last, input int rdy);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_value"}, 32'(out_value), 32'(val));
      check({tag, "_last"},  32'(out_last),  32'(last));
      check({tag, "_ready"}, 32'(in_ready),  32'(rdy));
      check({tag, "_err"},   32'(err),       32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_group  = 4'd0;
      out_ready = 1'b0;

      // Reset for two cycles
      step();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_value", 32'(out_value), 32'd0);
      check("rst_last",  32'(out_last),  32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_ready", 32'(in_ready),  32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);

      // Group 2 with out_ready high
      in_valid  = 1'b1;
      in_group  = 4'd2;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      beat("g2_b4", 4, 0, 0);
      step();
      beat("g2_b5", 5, 0, 0);
      step();
      beat("g2_b6", 6, 1, 1);
      step();
      check("g2_idle_valid", 32'(out_valid), 32'd0);
      check("g2_idle_ready", 32'(in_ready),  32'd1);

      // Groups 1 then 3 back to back
      in_valid = 1'b1;
      in_group = 4'd1;
      step();
      in_group = 4'd3;
      beat("bb_b1", 1, 0, 0);
      step();
      beat("bb_b2", 2, 0, 0);
      step();
      beat("bb_b3", 3, 1, 1);
      step();
      in_valid = 1'b0;
      beat("bb_b7", 7, 0, 0);
      step();
      beat("bb_b8", 8, 0, 0);
      step();
      beat("bb_b9", 9, 1, 1);
      step();
      check("bb_idle_valid", 32'(out_valid), 32'd0);

      // Group 3 with backpressure for 4 cycles on value 7
      in_valid = 1'b1;
      in_group = 4'd3;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      beat("bp_c1", 7, 0, 0);
      step();
      beat("bp_c2", 7, 0, 0);
      step();
      beat("bp_c3", 7, 0, 0);
      step();
      beat("bp_c4", 7, 0, 0);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'd0);
      step();
      beat("bp_b8", 8, 0, 0);
      step();
      beat("bp_b9", 9, 1, 1);
      step();
      check("bp_idle_valid", 32'(out_valid), 32'd0);

      // Illegal code 0
      in_valid = 1'b1;
      in_group = 4'd0;
      check("ill0_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("ill0_err",   32'(err),       32'd1);
      check("ill0_valid", 32'(out_valid), 32'd0);
      check("ill0_ready2", 32'(in_ready), 32'd1);
      step();
      check("ill0_err_end", 32'(err),       32'd0);
      check("ill0_valid2",  32'(out_valid), 32'd0);

      // Illegal code 4
      in_valid = 1'b1;
      in_group = 4'd4;
      step();
      in_valid = 1'b0;
      check("ill4_err",   32'(err),       32'd1);
      check("ill4_valid", 32'(out_valid), 32'd0);
      check("ill4_ready", 32'(in_ready),  32'd1);
      step();
      check("ill4_err_end", 32'(err),       32'd0);
      check("ill4_valid2",  32'(out_valid), 32'd0);

      // Reset mid-group, then a clean group 1
      in_valid = 1'b1;
      in_group = 4'd2;
      step();
      in_valid = 1'b0;
      beat("mr_b4", 4, 0, 0);
      step();
      beat("mr_b5", 5, 0, 0);
      reset = 1'b1;
      #1;
      check("mr_ready_in_rst", 32'(in_ready), 32'd0);
      step();
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_last",  32'(out_last),  32'd0);
      check("mr_err",   32'(err),       32'd0);
      reset    = 1'b0;
      in_valid = 1'b1;
      in_group = 4'd1;
      #1;
      check("mr_ready_after", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      beat("mr_b1", 1, 0, 0);
      step();
      beat("mr_b2", 2, 0, 0);
      step();
      beat("mr_b3", 3, 1, 1);
      step();
      check("mr_idle_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
